// File: rtl/mem_stack_unit_if.sv
// Data-memory bus between the stack/memory unit and a word-addressed
// 16-bit data memory with a combinational read port.
interface mem_stack_unit_if;
  logic [31:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_we;
  logic        dmem_re;
  logic [15:0] dmem_rdata;

  modport master (
    output dmem_addr,
    output dmem_wdata,
    output dmem_we,
    output dmem_re,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_we,
    input  dmem_re,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_stack_unit.sv
// Memory stage with stack pointer: 16-bit accesses finish in one cycle,
// 32-bit accesses take two (word 0 then word 1) and stall upstream for one.
// A 32-bit pop can return a PC (RET) and/or restore the {Z,N,C} flags.
module mem_stack_unit #(
  parameter logic [31:0] SP_RESET = 32'h0000_07FF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_type_in,
  input  logic              mem_addr_src_in,
  input  logic              mem_data_src_in,
  input  logic [1:0]        SP_src_in,
  input  logic              PC_push_pop_in,
  input  logic              flags_push_pop_in,
  input  logic [31:0]       PC_in,
  input  logic [15:0]       Rdst1_val_in,
  input  logic [15:0]       Rdst_val_in,
  input  logic [2:0]        Rdst1_in,
  input  logic              reglow_write_in,
  input  logic              memToReg_in,
  mem_stack_unit_if.master  bus,
  output logic              stall_out,
  output logic [2:0]        POP_flags_val_out,
  output logic              is_POP_flags_out,
  output logic [31:0]       ret_addr_out,
  output logic              do_ret_out,
  output logic [15:0]       wb_data_out,
  output logic [2:0]        wb_Rdst1_out,
  output logic              wb_reglow_write_out
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state_q, state_d;
  logic [31:0] sp_q;
  logic [15:0] hold_q;

  logic        access, is_write, is_read;
  logic        stall_int, last_cycle, widx, pop_done;
  logic [31:0] widx32, sp_step, popped;

  // Access decode; a simultaneous read and write is treated as a write.
  always_comb begin
    access     = mem_read_in | mem_write_in;
    is_write   = mem_write_in;
    is_read    = mem_read_in & ~mem_write_in;
    widx       = (state_q == SECOND);
    widx32     = {31'b0, widx};
    sp_step    = mem_type_in ? 32'd2 : 32'd1;
    last_cycle = ~stall_int;
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and stall: a 32-bit access spends one extra cycle in SECOND.
  always_comb begin
    state_d   = state_q;
    stall_int = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && mem_type_in) begin
          state_d   = SECOND;
          stall_int = 1'b1;
        end
      end
      SECOND:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address, write data and strobes for the word issued this cycle.
  always_comb begin
    if (mem_addr_src_in) begin
      bus.dmem_addr = {16'b0, Rdst1_val_in} + widx32;
    end else begin
      case (SP_src_in)
        2'd1:    bus.dmem_addr = sp_q - widx32;
        2'd2:    bus.dmem_addr = sp_q + 32'd1 + widx32;
        default: bus.dmem_addr = sp_q;
      endcase
    end
    if (mem_type_in)          bus.dmem_wdata = widx ? PC_in[15:0] : PC_in[31:16];
    else if (mem_data_src_in) bus.dmem_wdata = PC_in[15:0];
    else                      bus.dmem_wdata = Rdst_val_in;
    bus.dmem_we = access & is_write & ~reset;
    bus.dmem_re = access & is_read & ~reset;
    stall_out   = stall_int & ~reset;
  end

  // Stack pointer moves once per access, on its last cycle; wraps freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= SP_RESET;
    end else if (access && last_cycle) begin
      case (SP_src_in)
        2'd1:    sp_q <= sp_q - sp_step;
        2'd2:    sp_q <= sp_q + sp_step;
        default: sp_q <= sp_q;
      endcase
    end
  end

  // Word 0 of a 32-bit read is parked here until word 1 arrives.
  always_ff @(posedge clk) begin
    if (reset)                                      hold_q <= 16'h0000;
    else if (state_q == IDLE && is_read && mem_type_in) hold_q <= bus.dmem_rdata;
  end

  // RET / flag-restore pulses, live only in the cycle a 32-bit pop completes.
  always_comb begin
    popped            = {bus.dmem_rdata, hold_q};
    pop_done          = (state_q == SECOND) & is_read & mem_type_in &
                        (SP_src_in == 2'd2) & ~reset;
    do_ret_out        = pop_done & PC_push_pop_in;
    is_POP_flags_out  = pop_done & flags_push_pop_in;
    ret_addr_out      = do_ret_out ? {3'b000, popped[28:0]} : 32'h0;
    POP_flags_val_out = is_POP_flags_out ? popped[31:29] : 3'b000;
  end

  // Write-back register: loads on the last cycle, write-enable masked while stalling.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data_out         <= 16'h0000;
      wb_Rdst1_out        <= 3'b000;
      wb_reglow_write_out <= 1'b0;
    end else if (stall_int) begin
      wb_reglow_write_out <= 1'b0;
    end else begin
      wb_data_out         <= memToReg_in ? bus.dmem_rdata : Rdst1_val_in;
      wb_Rdst1_out        <= Rdst1_in;
      wb_reglow_write_out <= reglow_write_in;
    end
  end

endmodule

// File: tb/tb_mem_stack_unit.sv
// Directed bench for mem_stack_unit with a small behavioural data memory.
module tb_mem_stack_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_in, mem_write_in, mem_type_in, mem_addr_src_in, mem_data_src_in;
  logic [1:0]  SP_src_in;
  logic        PC_push_pop_in, flags_push_pop_in;
  logic [31:0] PC_in;
  logic [15:0] Rdst1_val_in, Rdst_val_in;
  logic [2:0]  Rdst1_in;
  logic        reglow_write_in, memToReg_in;
  logic        stall_out;
  logic [2:0]  POP_flags_val_out;
  logic        is_POP_flags_out;
  logic [31:0] ret_addr_out;
  logic        do_ret_out;
  logic [15:0] wb_data_out;
  logic [2:0]  wb_Rdst1_out;
  logic        wb_reglow_write_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [0:4095];

  mem_stack_unit_if bus ();

  mem_stack_unit #(.SP_RESET(32'h0000_07FF)) dut (
    .clk                 (clk),
    .reset               (reset),
    .mem_read_in         (mem_read_in),
    .mem_write_in        (mem_write_in),
    .mem_type_in         (mem_type_in),
    .mem_addr_src_in     (mem_addr_src_in),
    .mem_data_src_in     (mem_data_src_in),
    .SP_src_in           (SP_src_in),
    .PC_push_pop_in      (PC_push_pop_in),
    .flags_push_pop_in   (flags_push_pop_in),
    .PC_in               (PC_in),
    .Rdst1_val_in        (Rdst1_val_in),
    .Rdst_val_in         (Rdst_val_in),
    .Rdst1_in            (Rdst1_in),
    .reglow_write_in     (reglow_write_in),
    .memToReg_in         (memToReg_in),
    .bus                 (bus.master),
    .stall_out           (stall_out),
    .POP_flags_val_out   (POP_flags_val_out),
    .is_POP_flags_out    (is_POP_flags_out),
    .ret_addr_out        (ret_addr_out),
    .do_ret_out          (do_ret_out),
    .wb_data_out         (wb_data_out),
    .wb_Rdst1_out        (wb_Rdst1_out),
    .wb_reglow_write_out (wb_reglow_write_out)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, combinational read.
  always @(posedge clk) begin
    if (bus.dmem_we) mem[bus.dmem_addr[11:0]] <= bus.dmem_wdata;
  end
  assign bus.dmem_rdata = mem[bus.dmem_addr[11:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_read_in = 0; mem_write_in = 0; mem_type_in = 0;
    mem_addr_src_in = 0; mem_data_src_in = 0; SP_src_in = 2'd0;
    PC_push_pop_in = 0; flags_push_pop_in = 0; PC_in = 32'h0;
    Rdst1_val_in = 16'h0; Rdst_val_in = 16'h0; Rdst1_in = 3'd0;
    reglow_write_in = 0; memToReg_in = 0;
  endtask

  initial begin
    clear_inputs();
    // Reset with a write requested: strobes must stay low.
    reset = 1; mem_write_in = 1; mem_type_in = 1; Rdst1_val_in = 16'h9999; reglow_write_in = 1;
    @(negedge clk); #1;
    check_eq("rst_we", bus.dmem_we, 0);
    check_eq("rst_re", bus.dmem_re, 0);
    check_eq("rst_stall", stall_out, 0);
    @(negedge clk);
    reset = 0; clear_inputs(); #1;
    check_eq("rst_wb_data", wb_data_out, 0);
    check_eq("rst_wb_rdst", wb_Rdst1_out, 0);
    check_eq("rst_wb_rlw", wb_reglow_write_out, 0);

    // 16-bit push of Rdst_val at SP=0x7FF.
    @(negedge clk);
    clear_inputs(); mem_write_in = 1; SP_src_in = 2'd1; Rdst_val_in = 16'hABCD;
    Rdst1_val_in = 16'h1111; Rdst1_in = 3'd3; reglow_write_in = 1; #1;
    check_eq("push16_addr", bus.dmem_addr, 32'h7FF);
    check_eq("push16_wdata", bus.dmem_wdata, 16'hABCD);
    check_eq("push16_we", bus.dmem_we, 1);
    check_eq("push16_re", bus.dmem_re, 0);
    check_eq("push16_stall", stall_out, 0);
    @(posedge clk); #1;
    check_eq("push16_mem", mem[12'h7FF], 16'hABCD);
    check_eq("push16_wb_data", wb_data_out, 16'h1111);
    check_eq("push16_wb_rdst", wb_Rdst1_out, 3);
    check_eq("push16_wb_rlw", wb_reglow_write_out, 1);

    // 16-bit pop: SP=0x7FE reads SP+1, loads write-back from memory.
    @(negedge clk);
    clear_inputs(); mem_read_in = 1; SP_src_in = 2'd2; memToReg_in = 1;
    Rdst1_in = 3'd2; reglow_write_in = 1; #1;
    check_eq("pop16_addr", bus.dmem_addr, 32'h7FF);
    check_eq("pop16_re", bus.dmem_re, 1);
    @(posedge clk); #1;
    check_eq("pop16_wb_data", wb_data_out, 16'hABCD);

    // 32-bit PC push at SP=0x7FF.
    @(negedge clk);
    clear_inputs(); mem_write_in = 1; mem_type_in = 1; SP_src_in = 2'd1;
    PC_in = 32'hA000_1234; Rdst1_in = 3'd4; reglow_write_in = 1; #1;
    check_eq("push32_w0_addr", bus.dmem_addr, 32'h7FF);
    check_eq("push32_w0_data", bus.dmem_wdata, 16'hA000);
    check_eq("push32_w0_stall", stall_out, 1);
    check_eq("push32_w0_we", bus.dmem_we, 1);
    @(posedge clk); #1;
    check_eq("push32_stall_rlw", wb_reglow_write_out, 0);
    @(negedge clk); #1;
    check_eq("push32_w1_addr", bus.dmem_addr, 32'h7FE);
    check_eq("push32_w1_data", bus.dmem_wdata, 16'h1234);
    check_eq("push32_w1_stall", stall_out, 0);
    @(posedge clk); #1;
    check_eq("push32_mem_hi", mem[12'h7FF], 16'hA000);
    check_eq("push32_mem_lo", mem[12'h7FE], 16'h1234);
    check_eq("push32_wb_rlw", wb_reglow_write_out, 1);

    // 32-bit pop with RET and flag restore, SP=0x7FD.
    @(negedge clk);
    clear_inputs(); mem_read_in = 1; mem_type_in = 1; SP_src_in = 2'd2;
    PC_push_pop_in = 1; flags_push_pop_in = 1; #1;
    check_eq("pop32_w0_addr", bus.dmem_addr, 32'h7FE);
    check_eq("pop32_w0_stall", stall_out, 1);
    check_eq("pop32_w0_ret", do_ret_out, 0);
    check_eq("pop32_w0_raddr", ret_addr_out, 0);
    @(negedge clk); #1;
    check_eq("pop32_w1_addr", bus.dmem_addr, 32'h7FF);
    check_eq("pop32_w1_re", bus.dmem_re, 1);
    check_eq("pop32_w1_stall", stall_out, 0);
    check_eq("pop32_do_ret", do_ret_out, 1);
    check_eq("pop32_ret_addr", ret_addr_out, 32'h0000_1234);
    check_eq("pop32_is_flags", is_POP_flags_out, 1);
    check_eq("pop32_flags", POP_flags_val_out, 3'b101);

    // Read and write together act as a write; SP is back at 0x7FF.
    @(negedge clk);
    clear_inputs(); mem_read_in = 1; mem_write_in = 1; Rdst_val_in = 16'h00EE; #1;
    check_eq("rw_we", bus.dmem_we, 1);
    check_eq("rw_re", bus.dmem_re, 0);
    check_eq("rw_addr_sp", bus.dmem_addr, 32'h7FF);
    check_eq("rw_no_ret", do_ret_out, 0);

    // Store then load through the ALU address path.
    @(negedge clk);
    clear_inputs(); mem_write_in = 1; mem_addr_src_in = 1; Rdst1_val_in = 16'h0010;
    Rdst_val_in = 16'h5555; #1;
    check_eq("st_addr", bus.dmem_addr, 32'h10);
    @(negedge clk);
    clear_inputs(); mem_read_in = 1; mem_addr_src_in = 1; Rdst1_val_in = 16'h0010;
    memToReg_in = 1; Rdst1_in = 3'd6; reglow_write_in = 1; #1;
    check_eq("ld_addr", bus.dmem_addr, 32'h10);
    @(posedge clk); #1;
    check_eq("ld_wb_data", wb_data_out, 16'h5555);
    check_eq("ld_wb_rdst", wb_Rdst1_out, 6);

    // 32-bit ALU-addressed read: word index added to base.
    @(negedge clk);
    clear_inputs(); mem_read_in = 1; mem_type_in = 1; mem_addr_src_in = 1;
    Rdst1_val_in = 16'h000F; #1;
    check_eq("ld32_w0_addr", bus.dmem_addr, 32'h0F);
    @(negedge clk); #1;
    check_eq("ld32_w1_addr", bus.dmem_addr, 32'h10);

    // Move SP to 0x7FE, then abort a 32-bit pop with reset in SECOND.
    @(negedge clk);
    clear_inputs(); mem_write_in = 1; SP_src_in = 2'd1; Rdst_val_in = 16'h7777;
    @(negedge clk);
    clear_inputs(); mem_read_in = 1; mem_type_in = 1; SP_src_in = 2'd2;
    PC_push_pop_in = 1; flags_push_pop_in = 1; #1;
    check_eq("abort_w0_addr", bus.dmem_addr, 32'h7FF);
    check_eq("abort_w0_stall", stall_out, 1);
    @(negedge clk);
    reset = 1; #1;
    check_eq("abort_do_ret", do_ret_out, 0);
    check_eq("abort_is_flags", is_POP_flags_out, 0);
    check_eq("abort_re", bus.dmem_re, 0);
    check_eq("abort_stall", stall_out, 0);
    @(negedge clk);
    reset = 0; clear_inputs();
    Rdst1_val_in = 16'h2222; Rdst1_in = 3'd5; reglow_write_in = 1; #1;
    check_eq("abort_sp_reset", bus.dmem_addr, 32'h7FF);
    @(posedge clk); #1;
    check_eq("noacc_wb_data", wb_data_out, 16'h2222);
    check_eq("noacc_wb_rdst", wb_Rdst1_out, 5);
    check_eq("noacc_wb_rlw", wb_reglow_write_out, 1);

    // After the abort the sequencer starts from IDLE again.
    @(negedge clk);
    clear_inputs(); mem_read_in = 1; mem_type_in = 1; #1;
    check_eq("idle_after_abort", stall_out, 1);
    @(negedge clk); #1;
    check_eq("idle_second", stall_out, 0);
    @(negedge clk);
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
